ccd_readout_bin: RTL and testbench
==================================

Name: ccd_readout_bin

Overview:
- Single-clock, parametrised successor to the KAF/AD9826 readout sequencer.
- Generates CCD vertical/horizontal/reset clocks and AD9826 CDS/ADC strobes, and captures 16-bit pixel words from the 8-bit muxed ADC bus.
- Adds runtime horizontal/vertical binning, a tick divider in place of a separate module clock, abort, and a valid/ready pixel stream with frame/line markers.
- Sits between the host command decoder and the pixel FIFO.

Parameters:
- H_PIXELS, 2184, horizontal shifts per row (≥2).
- V_PIXELS, 1472, vertical transfers per frame (≥1).
- V_DELAY, 150, extra ticks spent in each of V1..V4 (state lasts V_DELAY+1 ticks).
- CLK_DIV, 2, clk cycles per sequencer tick (≥1; 1 = every cycle).
- CW, 12, h/v counter width; must hold max(H_PIXELS, V_PIXELS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; frame starts when high while idle
- mode  in  2  0 idle, 1 clean (no ADC), 2 readout, 3 binned readout
- hbin  in  3  horizontal bin factor 1..4 (0 and >4 treated as 1)
- vbin  in  3  vertical bin factor 1..4 (same clamp)
- abort  in  1  terminate frame
- busy  out  1  high unless sequencer idle
- ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n  out  1 each  AD9826 controls
- ad_data  in  8  AD9826 muxed output
- kaf_r, kaf_h1, kaf_v1, kaf_v2, kaf_amp  out  1 each  CCD clocks
- data_out  out  16  pixel word {high byte, low byte}
- data_valid  out  1  data_out valid
- data_ready  in  1  consumer accepts when valid&ready at a clk edge
- data_sof  out  1  qualifies first pixel of frame
- data_eol  out  1  qualifies last pixel of each output row

Behaviour:
- Reset (async, any time, including mid-frame): state IDLE, counters 0, data_out 0, data_valid/sof/eol 0, kaf_* 0, ad_adclk 1, ad_oeb_n 1, ad_cdsclk1/2 0, busy 0.
- Tick: a divider counts 0..CLK_DIV-1. The state register advances only on the tick cycle. Outputs are decoded from the registered state and are glitch-free.
- Start: in IDLE with start=1 and mode≠0, on a tick, latch mode/hbin/vbin (clamped), clear counters, go to V0. Inputs are ignored afterward until IDLE. mode=0 stays IDLE.
- Frame: ceil(V_PIXELS/vbin) row groups. Each group = vbin V-sequences (V0..V4), then H_PIXELS H-shifts.
  - V0: settle, 1 tick.
  - V1: kaf_v2=1.
  - V2: kaf_v1=1.
  - V3: kaf_v2=1.
  - V4: settle.
  - Throughout V0..V4: ad_adclk=1, ad_oeb_n=1.
  - After the last V4 of a group, enter H0 only if data_valid=0 (stall otherwise; clean mode never stalls).
- H shifts are grouped into bins of hbin. The last bin of a row may be short, closing at shift H_PIXELS.
  - Non-final shift of a bin: H0..H5 then H0.
  - Final shift of a bin: H0..H9.
  - kaf_h1=1 in H0..H4.
  - kaf_r=1 in H0 of first shift of a bin only.
  - ad_cdsclk1=1 in H2 of first shift only.
  - ad_cdsclk2=1 in H6..H8.
  - ad_adclk=1 in H0, H1, H7, H8, H9.
  - H3 of a final shift stalls while data_valid=1 (not in clean mode).
  - ad_data is captured to data_out[7:0] at H4 and to [15:8] at H9 of a final shift. data_valid sets on the H9 tick (not in clean mode).
- Binning applies only when mode=3. In mode 2, hbin and vbin are forced to 1.
- Output stream:
  - data_valid clears on the cycle after valid&ready.
  - data_out, data_sof and data_eol are stable while valid&!ready.
  - data_sof=1 for the first word of the frame. data_eol=1 for the word closing shift H_PIXELS.
  - Raw ADC words are emitted; pipeline-latency discard is done downstream.
- End: after the last row group's final H9, go to IDLE. A pending word remains valid until accepted.
- Clean mode: ad_cdsclk1/2 forced 0, ad_adclk and ad_oeb_n forced 1; no stalls, no data_valid.
- kaf_amp=1 whenever state≠IDLE and latched mode≠clean.
- busy=1 whenever state≠IDLE, or data_valid=1.
- Abort: on the next tick, go to IDLE and clear data_valid/sof/eol. Abort wins over start in the same cycle.
- Counter arithmetic is unsigned CW bits. Pixels per row = ceil(H_PIXELS/hbin). Frame words = rows × that.

Test Plan:
- H_PIXELS=4, V_PIXELS=5, V_DELAY=3, CLK_DIV=2, mode=2, data_ready=1, ad_data ramps -> 20 words. data_sof on word 0 only, data_eol on words 3,7,..,19. Each V1..V4 lasts 8 clk. busy falls after last accept.
- Same, mode=3, hbin=2, vbin=2 -> 3 rows×2 = 6 words. Kaf_r pulses 2 per row. 2 V-sequences before rows 0,1; 1 before row 2.
- hbin=3 with H_PIXELS=4 -> rows of 2 words (3+1 shifts), data_eol on second word.
- mode=1 -> zero data_valid, ad_cdsclk1/2=0, ad_adclk=ad_oeb_n=1 throughout, 5 V-sequences, 20 kaf_r pulses.
- data_ready held 0 after first word -> sequencer parks in H3 with data_out unchanged. Release -> resumes, no word lost or duplicated.
- rst_n low mid-H6, and separately abort mid-V2 -> IDLE outputs as specified. With rst_n the transition is immediate (asynchronous); with abort it occurs at the next tick. A new start then produces a full correct frame.

Source files
------------

// File: rtl/ccd_readout_bin_if.sv
// ccd_readout_bin_if: valid/ready pixel stream between the readout sequencer and the pixel FIFO
// master drives data_out/data_valid/data_sof/data_eol; slave drives data_ready
interface ccd_readout_bin_if;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        data_sof;
  logic        data_eol;
  modport master (output data_out, data_valid, data_sof, data_eol, input data_ready);
  modport slave (input data_out, data_valid, data_sof, data_eol, output data_ready);
endinterface

// File: rtl/ccd_readout_bin.sv
// ccd_readout_bin: KAF CCD clock / AD9826 strobe sequencer with runtime binning and a valid/ready pixel stream
// clk, rst_n (async active-low); start/mode/hbin/vbin/abort commands; busy status
// ad_cdsclk1/ad_cdsclk2/ad_adclk/ad_oeb_n, ad_data: AD9826; kaf_r/h1/v1/v2/amp: CCD clocks; s: pixel stream
module ccd_readout_bin #(
  parameter int H_PIXELS = 2184,
  parameter int V_PIXELS = 1472,
  parameter int V_DELAY  = 150,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [2:0]        hbin,
  input  logic [2:0]        vbin,
  input  logic              abort,
  output logic              busy,
  output logic              ad_cdsclk1,
  output logic              ad_cdsclk2,
  output logic              ad_adclk,
  output logic              ad_oeb_n,
  input  logic [7:0]        ad_data,
  output logic              kaf_r,
  output logic              kaf_h1,
  output logic              kaf_v1,
  output logic              kaf_v2,
  output logic              kaf_amp,
  ccd_readout_bin_if.master s
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [3:0] {IDLE, V0, V1, V2, V3, V4, H0, H1, H2, H3, H4, H5, H6, H7, H8, H9} state_t;
  state_t st, nx;
  logic [DW-1:0] div;
  logic [1:0] md, md_n;
  logic [2:0] hbf, hbf_n, vbf, vbf_n, hb, hb_n, vb, vb_n;
  logic [CW-1:0] lines, lines_n, hc, hc_n, dly, dly_n;
  logic [15:0] dout, dout_n;
  logic dv, dv_n, sof, sof_n, eol, eol_n, fw, fw_n;
  logic tick, cln, hfin, gend, vdone, rend, cl_n, f_n, hs_n;
  function automatic logic [2:0] clamp(input logic [2:0] x, input logic en);
    return (!en || x == 3'd0 || x > 3'd4) ? 3'd1 : x;
  endfunction
  assign tick = div == DW'(CLK_DIV - 1);
  assign cln = md == 2'd1;
  // a bin closes early when the row runs out of shifts; a group closes early when the frame runs out of lines
  assign hfin = hb == hbf - 3'd1 || rend;
  assign gend = vb == vbf - 3'd1 || lines == CW'(V_PIXELS - 1);
  assign vdone = dly == CW'(V_DELAY);
  assign rend = hc == CW'(H_PIXELS - 1);
  // strobes are registered from the next-state decode so they change exactly with the state register
  assign cl_n = md_n == 2'd1;
  assign f_n = hb_n == 3'd0;
  assign hs_n = nx >= H0;
  assign s.data_out = dout;
  assign s.data_valid = dv;
  assign s.data_sof = sof;
  assign s.data_eol = eol;
  always_comb begin
    nx = st;
    md_n = md;
    hbf_n = hbf;
    vbf_n = vbf;
    hb_n = hb;
    vb_n = vb;
    lines_n = lines;
    hc_n = hc;
    dly_n = dly;
    dout_n = dout;
    fw_n = fw;
    dv_n = dv && !s.data_ready;
    sof_n = sof && dv_n;
    eol_n = eol && dv_n;
    if (tick && abort) begin
      nx = IDLE;
      dv_n = 1'b0;
      sof_n = 1'b0;
      eol_n = 1'b0;
    end else if (tick) begin
      case (st)
        IDLE: if (start && mode != 2'd0) begin
          nx = V0;
          md_n = mode;
          hbf_n = clamp(hbin, mode == 2'd3);
          vbf_n = clamp(vbin, mode == 2'd3);
          hb_n = '0;
          vb_n = '0;
          lines_n = '0;
          hc_n = '0;
          dly_n = '0;
          fw_n = 1'b1;
        end
        V0: nx = V1;
        V1, V2, V3: begin
          dly_n = vdone ? '0 : dly + 1'b1;
          if (vdone) nx = st == V1 ? V2 : st == V2 ? V3 : V4;
        end
        V4: if (!vdone) dly_n = dly + 1'b1;
        else if (!gend) begin
          nx = V0;
          dly_n = '0;
          lines_n = lines + 1'b1;
          vb_n = vb + 1'b1;
        end else if (cln || !dv) begin
          nx = H0;
          dly_n = '0;
          lines_n = lines + 1'b1;
          vb_n = '0;
          hc_n = '0;
          hb_n = '0;
        end
        H3: if (!(hfin && dv && !cln)) nx = H4;
        H4: begin
          nx = H5;
          if (hfin && !cln) dout_n[7:0] = ad_data;
        end
        H5: if (hfin) nx = H6;
        else begin
          nx = H0;
          hc_n = hc + 1'b1;
          hb_n = hb + 1'b1;
        end
        H9: begin
          if (!cln) begin
            dout_n[15:8] = ad_data;
            dv_n = 1'b1;
            sof_n = fw;
            eol_n = rend;
            fw_n = 1'b0;
          end
          hb_n = '0;
          hc_n = rend ? '0 : hc + 1'b1;
          nx = !rend ? H0 : lines == CW'(V_PIXELS) ? IDLE : V0;
        end
        default: nx = state_t'(st + 4'd1);
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      div <= '0;
      md <= '0;
      hbf <= 3'd1;
      vbf <= 3'd1;
      hb <= '0;
      vb <= '0;
      lines <= '0;
      hc <= '0;
      dly <= '0;
      dout <= '0;
      dv <= 1'b0;
      sof <= 1'b0;
      eol <= 1'b0;
      fw <= 1'b0;
      busy <= 1'b0;
      kaf_r <= 1'b0;
      kaf_h1 <= 1'b0;
      kaf_v1 <= 1'b0;
      kaf_v2 <= 1'b0;
      kaf_amp <= 1'b0;
      ad_cdsclk1 <= 1'b0;
      ad_cdsclk2 <= 1'b0;
      ad_adclk <= 1'b1;
      ad_oeb_n <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      st <= nx;
      md <= md_n;
      hbf <= hbf_n;
      vbf <= vbf_n;
      hb <= hb_n;
      vb <= vb_n;
      lines <= lines_n;
      hc <= hc_n;
      dly <= dly_n;
      dout <= dout_n;
      dv <= dv_n;
      sof <= sof_n;
      eol <= eol_n;
      fw <= fw_n;
      busy <= nx != IDLE || dv_n;
      kaf_r <= nx == H0 && f_n;
      kaf_h1 <= nx >= H0 && nx <= H4;
      kaf_v1 <= nx == V2;
      kaf_v2 <= nx == V1 || nx == V3;
      kaf_amp <= nx != IDLE && !cl_n;
      ad_cdsclk1 <= !cl_n && nx == H2 && f_n;
      ad_cdsclk2 <= !cl_n && (nx == H6 || nx == H7 || nx == H8);
      ad_adclk <= cl_n || !hs_n || nx == H0 || nx == H1 || nx == H7 || nx == H8 || nx == H9;
      ad_oeb_n <= cl_n || !hs_n;
    end
endmodule

// File: tb/tb_ccd_readout_bin.sv
// tb_ccd_readout_bin: directed frames (readout, binning, clean, backpressure, reset, abort) against hand-computed results
module tb_ccd_readout_bin;
  localparam int VP = 5;
  typedef struct packed {logic [15:0] d; logic sof; logic eol;} word_t;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] hbin = 3'd1, vbin = 3'd1;
  logic busy, ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, kaf_r, kaf_h1, kaf_v1, kaf_v2, kaf_amp;
  logic [7:0] ad_data;
  logic [7:0] p = 8'd0;
  logic kr_d = 1'b0, v1_d = 1'b0, h1_d = 1'b0, c1_d = 1'b0;
  int checks = 0, errors = 0;
  int kr_cnt = 0, v1_cnt = 0, viol = 0, v1_run = 0, v1_last = 0, vsince = 0;
  int w0, k0, v0, q0, x0;
  word_t words[$];
  int vq[$];
  ccd_readout_bin_if s();
  ccd_readout_bin #(.H_PIXELS(4), .V_PIXELS(VP), .V_DELAY(3), .CLK_DIV(2), .CW(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hbin(hbin), .vbin(vbin), .abort(abort),
    .busy(busy), .ad_cdsclk1(ad_cdsclk1), .ad_cdsclk2(ad_cdsclk2), .ad_adclk(ad_adclk), .ad_oeb_n(ad_oeb_n),
    .ad_data(ad_data), .kaf_r(kaf_r), .kaf_h1(kaf_h1), .kaf_v1(kaf_v1), .kaf_v2(kaf_v2), .kaf_amp(kaf_amp),
    .s(s)
  );
  always #5 clk = ~clk;
  assign ad_data = ad_adclk ? (p ^ 8'hA5) : p;
  always @(negedge clk) begin
    if (s.data_valid && s.data_ready) words.push_back({s.data_out, s.data_sof, s.data_eol});
    if (kaf_r && !kr_d) kr_cnt++;
    if (kaf_v1 && !v1_d) begin
      v1_cnt++;
      vsince++;
    end
    if (kaf_v1) v1_run++;
    else begin
      if (v1_d) v1_last = v1_run;
      v1_run = 0;
    end
    if (kaf_h1 && !h1_d && vsince > 0) begin
      vq.push_back(vsince);
      vsince = 0;
    end
    if (ad_cdsclk1 && !c1_d) p++;
    if (mode == 2'd1 && busy && (ad_cdsclk1 || ad_cdsclk2 || !ad_adclk || !ad_oeb_n || kaf_amp)) viol++;
    if (!busy) begin
      p = 8'd0;
      vsince = 0;
    end
    kr_d = kaf_r;
    v1_d = kaf_v1;
    h1_d = kaf_h1;
    c1_d = ad_cdsclk1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic snap();
    w0 = words.size();
    k0 = kr_cnt;
    v0 = v1_cnt;
    q0 = vq.size();
    x0 = viol;
  endtask
  task automatic start_frame(input logic [1:0] md, input logic [2:0] hb, input logic [2:0] vb);
    mode = md;
    hbin = hb;
    vbin = vb;
    start = 1'b1;
    for (int i = 0; i < 20 && !busy; i++) cyc(1);
    chk("start_busy", busy, 1);
    start = 1'b0;
    hbin = 3'd4;
    vbin = 3'd4;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) cyc(1);
    chk("idle_timeout", busy, 0);
  endtask
  task automatic check_frame(input int n, input int wpr, input int nkr, input int vb);
    int rows;
    logic [7:0] e;
    word_t w;
    chk("nwords", words.size() - w0, n);
    for (int k = 0; k < n && w0 + k < words.size(); k++) begin
      w = words[w0 + k];
      e = 8'(k + 1);
      chk("data", w.d, {e ^ 8'hA5, e});
      chk("sof", w.sof, k == 0);
      chk("eol", w.eol, (k % wpr) == wpr - 1);
    end
    chk("kaf_r", kr_cnt - k0, nkr);
    chk("vseq", v1_cnt - v0, VP);
    chk("v1_len", v1_last, 8);
    chk("clean_viol", viol - x0, 0);
    rows = (VP + vb - 1) / vb;
    for (int r = 0; r < rows; r++)
      chk("vrow", q0 + r < vq.size() ? vq[q0 + r] : -1, VP - r * vb < vb ? VP - r * vb : vb);
    chk("end_valid", s.data_valid, 0);
  endtask
  task automatic idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_adclk"}, ad_adclk, 1);
    chk({tag, "_oeb"}, ad_oeb_n, 1);
    chk({tag, "_cds"}, {ad_cdsclk1, ad_cdsclk2}, 0);
    chk({tag, "_kaf"}, {kaf_r, kaf_h1, kaf_v1, kaf_v2, kaf_amp}, 0);
    chk({tag, "_valid"}, {s.data_valid, s.data_sof, s.data_eol}, 0);
  endtask
  initial begin
    s.data_ready = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    idle_outputs("reset");
    chk("reset_data", s.data_out, 0);
    rst_n = 1'b1;
    cyc(2);
    mode = 2'd2;
    start = 1'b1;
    abort = 1'b1;
    cyc(6);
    chk("abort_vs_start", busy, 0);
    start = 1'b0;
    abort = 1'b0;
    cyc(2);
    snap();
    start_frame(2'd2, 3'd1, 3'd1);
    wait_idle();
    check_frame(20, 4, 20, 1);
    snap();
    start_frame(2'd3, 3'd2, 3'd2);
    wait_idle();
    check_frame(6, 2, 6, 2);
    snap();
    start_frame(2'd3, 3'd3, 3'd1);
    wait_idle();
    check_frame(10, 2, 10, 1);
    snap();
    start_frame(2'd1, 3'd1, 3'd1);
    wait_idle();
    check_frame(0, 1, 20, 1);
    snap();
    start_frame(2'd2, 3'd1, 3'd1);
    for (int i = 0; i < 2000 && words.size() == w0; i++) cyc(1);
    s.data_ready = 1'b0;
    chk("bp_first", words.size() - w0, 1);
    cyc(300);
    chk("park_valid", s.data_valid, 1);
    chk("park_data", s.data_out, 16'hA702);
    chk("park_h1", kaf_h1, 1);
    chk("park_adclk", ad_adclk, 0);
    chk("park_amp", kaf_amp, 1);
    cyc(40);
    chk("park_hold", s.data_out, 16'hA702);
    chk("park_h1_hold", kaf_h1, 1);
    s.data_ready = 1'b1;
    wait_idle();
    check_frame(20, 4, 20, 1);
    start_frame(2'd2, 3'd1, 3'd1);
    for (int i = 0; i < 2000 && !ad_cdsclk2; i++) cyc(1);
    chk("saw_h6", ad_cdsclk2, 1);
    #2 rst_n = 1'b0;
    #1 idle_outputs("async_rst");
    chk("async_rst_data", s.data_out, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    snap();
    start_frame(2'd2, 3'd1, 3'd1);
    wait_idle();
    check_frame(20, 4, 20, 1);
    start_frame(2'd2, 3'd1, 3'd1);
    for (int i = 0; i < 2000 && !kaf_v1; i++) cyc(1);
    cyc(3);
    chk("v2_before_abort", kaf_v1, 1);
    abort = 1'b1;
    cyc(2);
    idle_outputs("abort");
    abort = 1'b0;
    cyc(2);
    snap();
    start_frame(2'd2, 3'd1, 3'd1);
    wait_idle();
    check_frame(20, 4, 20, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
